// File: rtl/ex_result_queue_pkg.sv
// ex_result_queue_pkg
//   Shared widths and the queue entry layout for the execute result queue.
//   DWIDTH   : ALU result width
//   PC_WIDTH : redirect target width
//   AWIDTH   : register index width
package ex_result_queue_pkg;

  localparam int unsigned DWIDTH   = 32;
  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned AWIDTH   = 5;

  // Entry layout, MSB to LSB: {reg_write, rd, value}
  typedef struct packed {
    logic              reg_write;
    logic [AWIDTH-1:0] rd;
    logic [DWIDTH-1:0] value;
  } exq_entry_t;

endpackage

// File: rtl/ex_result_mem.sv
// ex_result_mem
//   DEPTH x exq_entry_t register array, one synchronous write port and one
//   asynchronous read port. Contents are never reset or cleared.
//   Ports:
//     clk     in  clock
//     we_i    in  write enable
//     waddr_i in  write index
//     wdata_i in  write entry
//     raddr_i in  read index
//     rdata_o out entry at raddr_i (combinational)
module ex_result_mem
  import ex_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  exq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output exq_entry_t    rdata_o
);

  exq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ex_result_queue.sv
// ex_result_queue
//   Queue of execute-stage results waiting for writeback. A pushed entry
//   becomes visible on o_wb_* the cycle after the push (no bypass). A push
//   carrying i_change_pc raises o_redirect for one cycle with the target.
//   i_flush drops all entries and overrides push/pop.
//   Optional build macro: EXQ_RD_ZERO_FILTER_EN -- clear the stored
//   reg_write bit when the destination register is 0.
//   Ports:
//     clk, rst_n                      clock, synchronous active-low reset
//     i_valid/i_ready                 upstream handshake (i_ready = !full)
//     i_check_queue                   0 drops the beat without side effects
//     i_value, i_rd, i_reg_write      result fields to enqueue
//     i_change_pc, i_pc               redirect request and target
//     i_flush                         discard all entries
//     o_wb_valid/o_wb_ready           writeback handshake on the head entry
//     o_wb_value, o_wb_rd, o_wb_reg_write  head entry fields
//     o_redirect, o_redirect_pc       registered one-cycle redirect pulse
//     o_count                         occupancy
module ex_result_queue
  import ex_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTRW = $clog2(DEPTH),
  localparam int unsigned CNTW = PTRW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic                i_check_queue,
  input  logic [DWIDTH-1:0]   i_value,
  input  logic [AWIDTH-1:0]   i_rd,
  input  logic                i_reg_write,
  input  logic                i_change_pc,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  output logic                o_wb_valid,
  input  logic                o_wb_ready,
  output logic [DWIDTH-1:0]   o_wb_value,
  output logic [AWIDTH-1:0]   o_wb_rd,
  output logic                o_wb_reg_write,
  output logic                o_redirect,
  output logic [PC_WIDTH-1:0] o_redirect_pc,
  output logic [CNTW-1:0]     o_count
);

  logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic                redirect_q, redirect_d;
  logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic       full;
  logic       push;
  logic       pop;
  exq_entry_t wr_entry;
  exq_entry_t head;

  // Full blocks push even when a pop happens in the same cycle.
  assign full       = (count_q == CNTW'(DEPTH));
  assign i_ready    = !full;
  assign o_wb_valid = (count_q != '0);
  assign push       = i_valid && i_ready && i_check_queue && !i_flush;
  assign pop        = o_wb_valid && o_wb_ready && !i_flush;

  always_comb begin
    wr_entry.value     = i_value;
    wr_entry.rd        = i_rd;
    wr_entry.reg_write = i_reg_write;
`ifdef EXQ_RD_ZERO_FILTER_EN
    if (i_rd == '0) begin
      wr_entry.reg_write = 1'b0;
    end
`endif
  end

  ex_result_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign o_wb_value     = head.value;
  assign o_wb_rd        = head.rd;
  assign o_wb_reg_write = head.reg_write;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
      if (push && i_change_pc) begin
        redirect_d    = 1'b1;
        redirect_pc_d = i_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_count       = count_q;

endmodule

// File: tb/tb_ex_result_queue.sv
module tb_ex_result_queue;
  import ex_result_queue_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                i_valid;
  logic                i_ready;
  logic                i_check_queue;
  logic [DWIDTH-1:0]   i_value;
  logic [AWIDTH-1:0]   i_rd;
  logic                i_reg_write;
  logic                i_change_pc;
  logic [PC_WIDTH-1:0] i_pc;
  logic                i_flush;
  logic                o_wb_valid;
  logic                o_wb_ready;
  logic [DWIDTH-1:0]   o_wb_value;
  logic [AWIDTH-1:0]   o_wb_rd;
  logic                o_wb_reg_write;
  logic                o_redirect;
  logic [PC_WIDTH-1:0] o_redirect_pc;
  logic [2:0]          o_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ex_result_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .i_check_queue  (i_check_queue),
    .i_value        (i_value),
    .i_rd           (i_rd),
    .i_reg_write    (i_reg_write),
    .i_change_pc    (i_change_pc),
    .i_pc           (i_pc),
    .i_flush        (i_flush),
    .o_wb_valid     (o_wb_valid),
    .o_wb_ready     (o_wb_ready),
    .o_wb_value     (o_wb_value),
    .o_wb_rd        (o_wb_rd),
    .o_wb_reg_write (o_wb_reg_write),
    .o_redirect     (o_redirect),
    .o_redirect_pc  (o_redirect_pc),
    .o_count        (o_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    i_valid       = 1'b0;
    i_check_queue = 1'b1;
    i_value       = '0;
    i_rd          = '0;
    i_reg_write   = 1'b0;
    i_change_pc   = 1'b0;
    i_pc          = '0;
    i_flush       = 1'b0;
    o_wb_ready    = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %0b expected 0", o_wb_valid); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready: got %0b expected 1", i_ready); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", o_count); else pass_cnt++;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL reset_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    total_cnt++; if (o_redirect_pc !== 32'h0) $display("FAIL reset_redirect_pc: got %h expected 0", o_redirect_pc); else pass_cnt++;
  endtask

  task automatic test_basic_push;
    i_valid = 1'b1; i_value = 32'h11; i_rd = 5'd3; i_reg_write = 1'b1;
    total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL basic_no_bypass: got %0b expected 0", o_wb_valid); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (o_wb_valid !== 1'b1) $display("FAIL basic_wb_valid: got %0b expected 1", o_wb_valid); else pass_cnt++;
    total_cnt++; if (o_wb_value !== 32'h11) $display("FAIL basic_value: got %h expected 11", o_wb_value); else pass_cnt++;
    total_cnt++; if (o_wb_rd !== 5'd3) $display("FAIL basic_rd: got %0d expected 3", o_wb_rd); else pass_cnt++;
    total_cnt++; if (o_wb_reg_write !== 1'b1) $display("FAIL basic_reg_write: got %0b expected 1", o_wb_reg_write); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd1) $display("FAIL basic_count: got %0d expected 1", o_count); else pass_cnt++;
    o_wb_ready = 1'b1;
    tick();
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL basic_pop_count: got %0d expected 0", o_count); else pass_cnt++;
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_value = 32'hA0 + 32'(i); i_rd = 5'(i + 1); i_reg_write = 1'b1;
      tick();
    end
    idle();
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL full_i_ready: got %0b expected 0", i_ready); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", o_count); else pass_cnt++;
    total_cnt++; if (o_wb_value !== 32'hA0) $display("FAIL full_head: got %h expected a0", o_wb_value); else pass_cnt++;
    // Redirect request while full is not accepted.
    i_valid = 1'b1; i_value = 32'hBB; i_change_pc = 1'b1; i_pc = 32'h99;
    tick();
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL full_no_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd4) $display("FAIL full_hold_count: got %0d expected 4", o_count); else pass_cnt++;
    // Push and pop together at full: only the pop happens.
    o_wb_ready = 1'b1;
    total_cnt++; if (i_ready !== 1'b0) $display("FAIL full_pop_i_ready: got %0b expected 0", i_ready); else pass_cnt++;
    tick();
    i_valid = 1'b0; i_change_pc = 1'b0;
    total_cnt++; if (o_count !== 3'd3) $display("FAIL full_pushpop_count: got %0d expected 3", o_count); else pass_cnt++;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL full_pushpop_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      total_cnt++; if (o_wb_value !== 32'hA0 + 32'(i)) $display("FAIL full_drain_value: got %h expected %h", o_wb_value, 32'hA0 + 32'(i)); else pass_cnt++;
      total_cnt++; if (o_wb_rd !== 5'(i + 1)) $display("FAIL full_drain_rd: got %0d expected %0d", o_wb_rd, i + 1); else pass_cnt++;
      tick();
    end
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL full_drained_count: got %0d expected 0", o_count); else pass_cnt++;
    total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL full_drained_valid: got %0b expected 0", o_wb_valid); else pass_cnt++;
  endtask

  task automatic test_redirect;
    i_valid = 1'b1; i_value = 32'h22; i_rd = 5'd5; i_reg_write = 1'b1;
    i_change_pc = 1'b1; i_pc = 32'h40;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL redir_early: got %0b expected 0", o_redirect); else pass_cnt++;
    tick();
    idle();
    total_cnt++; if (o_redirect !== 1'b1) $display("FAIL redir_pulse: got %0b expected 1", o_redirect); else pass_cnt++;
    total_cnt++; if (o_redirect_pc !== 32'h40) $display("FAIL redir_pc: got %h expected 40", o_redirect_pc); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd1) $display("FAIL redir_count: got %0d expected 1", o_count); else pass_cnt++;
    total_cnt++; if (o_wb_value !== 32'h22) $display("FAIL redir_value: got %h expected 22", o_wb_value); else pass_cnt++;
    tick();
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL redir_one_cycle: got %0b expected 0", o_redirect); else pass_cnt++;
    o_wb_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_drop;
    i_valid = 1'b1; i_value = 32'h33; i_rd = 5'd7; i_reg_write = 1'b1;
    tick();
    i_check_queue = 1'b0; i_value = 32'h44; i_change_pc = 1'b1; i_pc = 32'h80;
    tick();
    idle();
    total_cnt++; if (o_count !== 3'd1) $display("FAIL drop_count: got %0d expected 1", o_count); else pass_cnt++;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL drop_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    total_cnt++; if (o_wb_value !== 32'h33) $display("FAIL drop_head: got %h expected 33", o_wb_value); else pass_cnt++;
    o_wb_ready = 1'b1;
    tick();
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL drop_drain: got %0d expected 0", o_count); else pass_cnt++;
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_value = 32'h61 + 32'(i); i_rd = 5'd9;
      tick();
    end
    idle();
    total_cnt++; if (o_count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", o_count); else pass_cnt++;
    i_flush = 1'b1; i_valid = 1'b1; i_value = 32'h6F; i_change_pc = 1'b1; i_pc = 32'h123;
    o_wb_ready = 1'b1;
    tick();
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", o_count); else pass_cnt++;
    total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL flush_wb_valid: got %0b expected 0", o_wb_valid); else pass_cnt++;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL flush_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL flush_i_ready: got %0b expected 1", i_ready); else pass_cnt++;
    i_valid = 1'b1; i_value = 32'h70; i_rd = 5'd2;
    tick();
    idle();
    total_cnt++; if (o_wb_value !== 32'h70) $display("FAIL flush_repush_value: got %h expected 70", o_wb_value); else pass_cnt++;
    total_cnt++; if (o_count !== 3'd1) $display("FAIL flush_repush_count: got %0d expected 1", o_count); else pass_cnt++;
    o_wb_ready = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_back_to_back;
    logic exp_rw;
    o_wb_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      // Each entry surfaces the cycle after its push and is popped at once.
      if (c == 0) begin
        total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL b2b_start_valid: got %0b expected 0", o_wb_valid); else pass_cnt++;
      end else begin
        exp_rw = 1'b1;
`ifdef EXQ_RD_ZERO_FILTER_EN
        if (((c - 1) % 8) == 0) exp_rw = 1'b0;
`endif
        total_cnt++; if (o_wb_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %0b expected 1", c, o_wb_valid); else pass_cnt++;
        total_cnt++; if (o_wb_value !== 32'h100 + 32'(c - 1)) $display("FAIL b2b_value[%0d]: got %h expected %h", c, o_wb_value, 32'h100 + 32'(c - 1)); else pass_cnt++;
        total_cnt++; if (o_wb_rd !== 5'((c - 1) % 8)) $display("FAIL b2b_rd[%0d]: got %0d expected %0d", c, o_wb_rd, (c - 1) % 8); else pass_cnt++;
        total_cnt++; if (o_wb_reg_write !== exp_rw) $display("FAIL b2b_reg_write[%0d]: got %0b expected %0b", c, o_wb_reg_write, exp_rw); else pass_cnt++;
        total_cnt++; if (o_count !== 3'd1) $display("FAIL b2b_count[%0d]: got %0d expected 1", c, o_count); else pass_cnt++;
      end
      if (c < 10) begin
        i_valid = 1'b1; i_value = 32'h100 + 32'(c); i_rd = 5'(c % 8); i_reg_write = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      tick();
    end
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL b2b_end_count: got %0d expected 0", o_count); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    i_valid = 1'b1; i_value = 32'h55; i_rd = 5'd4; i_change_pc = 1'b1; i_pc = 32'h77;
    tick();
    total_cnt++; if (o_redirect_pc !== 32'h77) $display("FAIL mreset_pre_pc: got %h expected 77", o_redirect_pc); else pass_cnt++;
    i_value = 32'h56; i_pc = 32'h78;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    total_cnt++; if (o_count !== 3'd0) $display("FAIL mreset_count: got %0d expected 0", o_count); else pass_cnt++;
    total_cnt++; if (o_wb_valid !== 1'b0) $display("FAIL mreset_wb_valid: got %0b expected 0", o_wb_valid); else pass_cnt++;
    total_cnt++; if (o_redirect !== 1'b0) $display("FAIL mreset_redirect: got %0b expected 0", o_redirect); else pass_cnt++;
    total_cnt++; if (o_redirect_pc !== 32'h0) $display("FAIL mreset_redirect_pc: got %h expected 0", o_redirect_pc); else pass_cnt++;
    total_cnt++; if (i_ready !== 1'b1) $display("FAIL mreset_i_ready: got %0b expected 1", i_ready); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    test_reset();
    test_basic_push();
    test_full();
    test_redirect();
    test_drop();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
